irq_pending_latch: RTL

- Upstream stage of the 8-to-3 priority encoder.
- Synchronises raw interrupt lines, detects rising edges and holds them as pending bits.
- Drives the masked pending vector into the encoder's `in`.
- Clears the serviced bit when the consumer acknowledges with the encoder's `code`.
- Runs a small request/acknowledge FSM so the consumer sees one stable request at a time.

---
 rtl/irq_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 26 ++
 rtl/irq_pending_latch.sv | 101 ++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and default widths for the interrupt pending latch.
package irq_pkg;

  localparam int unsigned IRQ_N  = 8;
  localparam int unsigned IRQ_CW = $clog2(IRQ_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser with rising-edge detection on the synchronised level.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Latches synchronised interrupt edges as pending bits and hands them to the
// consumer one request at a time. Define IRQ_PENDING_LATCH_LOST_EN to add the
// sticky `lost` vector for events that merged into an already-pending bit.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int unsigned N           = IRQ_N,
  parameter int unsigned CW          = IRQ_CW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  irq_raw,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  pending,
  output logic          irq_req,
  input  logic          ack,
  input  logic [CW-1:0] ack_code,
  output logic          busy
`ifdef IRQ_PENDING_LATCH_LOST_EN
  ,
  output logic [N-1:0]  lost
`endif
);

  irq_state_e   state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] rise;
  logic [N-1:0] clr_c;
  logic         accept_c;

  for (genvar g = 0; g < N; g++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (irq_raw[g]),
      .rise_c(rise[g])
    );
  end

  // Mask only gates visibility; capture is unconditional.
  assign pending = pend_q & mask;

  // Next state and acknowledge acceptance.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) state_d = REQ;
      end
      REQ: begin
        if (ack) begin
          accept_c = 1'b1;
          state_d  = SETTLE;
        end else if (!(|pending)) begin
          state_d = IDLE;
        end
      end
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-range codes match no index and clear nothing; a new edge beats the clear.
  always_comb begin
    clr_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      clr_c[i] = accept_c && (32'(ack_code) == i);
    end
    pend_d = (pend_q & ~clr_c) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      irq_req <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      irq_req <= (state_d == REQ);
      busy    <= (state_d != IDLE);
    end
  end

`ifdef IRQ_PENDING_LATCH_LOST_EN
  // Sticky overflow: edge onto a pending bit that is not being cleared this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost <= '0;
    end else begin
      lost <= (lost & ~clr_c) | (rise & pend_q & ~clr_c);
    end
  end
`endif

endmodule
